uart_cmd_responder: RTL
=======================

Name: uart_cmd_responder

Overview:
- Device-side command responder inside dig_core, between the UART receiver/transmitter pair and the core's register space.
- Assembles 3-byte host frames (opcode, address, data) from received bytes and executes register writes and reads.
- Returns exactly one response byte per valid-length frame through the UART transmit handshake.
- Exposes the register file and register 0 as the debug byte.

Parameters:
NUM_REGS, 4, number of 8-bit registers; valid addresses 0..NUM_REGS-1
TIMEOUT_CYCLES, 1000000, idle clk cycles between bytes of one frame before the partial frame is discarded
ACK_BYTE, 8'h55, response to a successful write
NAK_BYTE, 8'hEE, response to a bad opcode or out-of-range address

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data_i  in  8  received byte; valid when rx_done_i is high
rx_done_i  in  1  one-cycle strobe, byte received
tx_data_o  out  8  byte to transmit
tx_wr_o  out  1  one-cycle strobe, start transmission of tx_data_o
tx_done_i  in  1  one-cycle strobe, transmitter finished the byte
regs_o  out  8*NUM_REGS  register file, reg k at bits [8k+7:8k]
debug_o  out  8  equals reg 0
busy_o  out  1  high from the first byte of a frame until the response tx_done_i

Behaviour:
- Reset, applied asynchronously: state IDLE; all regs 0; tx_data_o 0; tx_wr_o 0; busy_o 0; timeout counter 0.
- Opcodes:
  - 8'hA1 = write: reg[addr] <= data.
  - 8'hA2 = read: data byte is ignored.
  - Any other opcode is invalid.
- FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_DONE.
- IDLE: on rx_done_i, latch opcode (any value) -> GET_ADDR; busy_o=1.
- GET_ADDR: on rx_done_i, latch addr -> GET_DATA.
- GET_DATA: on rx_done_i, latch data -> EXEC.
- Timeout in GET_ADDR or GET_DATA:
  - Counter clears on every rx_done_i and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: -> IDLE, busy_o=0, no response, no register change.
- EXEC (exactly 1 cycle), selects the response byte:
  - Invalid opcode: NAK_BYTE.
  - addr >= NUM_REGS: NAK_BYTE.
  - Valid write: commit the write this cycle; response ACK_BYTE.
  - Valid read: response = current reg[addr].
  - Always -> SEND.
- SEND (1 cycle): tx_wr_o=1, tx_data_o = response -> WAIT_DONE.
- Response latency: tx_wr_o rises 2 clk after the cycle in which the third rx_done_i is sampled.
- tx_data_o holds its value from SEND until the next SEND.
- WAIT_DONE: on tx_done_i -> IDLE; busy_o=0 in the same cycle.
- tx_done_i outside WAIT_DONE is ignored.
- rx_done_i in EXEC, SEND or WAIT_DONE: byte dropped, no frame started. The host must wait for the response before sending.
- Write followed by read of the same address: the read returns the new value. The write commits in EXEC, and regs_o/debug_o update the cycle after EXEC.
- Address compare uses all 8 addr bits; no truncation or wrap-around.
- Reset mid-frame or mid-response: frame abandoned, tx_wr_o deasserts immediately, regs return to 0.

Test Plan:
- Reset, then send A1 00 01 -> one tx_wr_o pulse with tx_data_o=8'h55; debug_o=8'h01 and regs_o[7:0]=8'h01 from the cycle after EXEC.
- After the write above, send A2 00 FF -> response 8'h01; regs unchanged.
- Send A1 03 7C, then A2 03 00 -> responses 8'h55 then 8'h7C; regs_o[31:24]=8'h7C.
- Send 33 00 01 -> response 8'hEE, regs unchanged.
- Send A1 05 AA (NUM_REGS=4) -> response 8'hEE, regs unchanged.
- Timeout:
  - Set TIMEOUT_CYCLES=5000 and send A1.
  - Idle more than 5000 clk, then send A2 00 00 -> single response equal to reg 0, with no response for the discarded A1.
- Reset mid-frame:
  - Send A1 00, assert rst_n=0 for 100 ns, then send A2 00 00.
  - Required: response 8'h00, no stray tx_wr_o, busy_o=0 after reset.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: assembles 3-byte host frames (opcode, addr, data), executes
// register writes/reads and returns one response byte per frame over the UART tx handshake.
module uart_cmd_responder #(
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE = 8'h55,
  parameter logic [7:0] NAK_BYTE = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_done_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_wr_o,
  input  logic                  tx_done_i,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic [7:0]            debug_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] OP_WR = 8'hA1;
  localparam logic [7:0] OP_RD = 8'hA2;

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_DONE} state_t;

  state_t                      r_state;
  logic [NUM_REGS-1:0][7:0]    r_regs;
  logic [7:0]                  r_op, r_addr, r_data, r_tx_data;
  logic [CW-1:0]               r_cnt;
  logic                        r_tx_wr, r_busy;
  logic                        w_addr_ok, w_op_ok, w_wr, w_timeout;
  logic [IW-1:0]               w_idx;
  logic [7:0]                  w_resp;

  // full 8-bit address compare, no wrap-around into the register file
  assign w_addr_ok = 32'(r_addr) < NUM_REGS;
  assign w_op_ok   = r_op == OP_WR || r_op == OP_RD;
  assign w_idx     = r_addr[IW-1:0];
  assign w_wr      = w_op_ok && w_addr_ok && r_op == OP_WR;
  assign w_resp    = !(w_op_ok && w_addr_ok) ? NAK_BYTE : r_op == OP_WR ? ACK_BYTE : r_regs[w_idx];
  assign w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_regs    <= '0;
      r_op      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_tx_data <= '0;
      r_tx_wr   <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_tx_wr <= 1'b0;
      case (r_state)
        IDLE: if (rx_done_i) begin
          r_op    <= rx_data_i;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= GET_ADDR;
        end
        GET_ADDR, GET_DATA: if (rx_done_i) begin
          r_cnt <= '0;
          if (r_state == GET_ADDR) begin
            r_addr  <= rx_data_i;
            r_state <= GET_DATA;
          end else begin
            r_data  <= rx_data_i;
            r_state <= EXEC;
          end
        end else if (w_timeout) begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end else r_cnt <= r_cnt + 1'b1;
        EXEC: begin
          if (w_wr) r_regs[w_idx] <= r_data;
          r_tx_data <= w_resp;
          r_tx_wr   <= 1'b1;
          r_state   <= SEND;
        end
        SEND: r_state <= WAIT_DONE;
        WAIT_DONE: if (tx_done_i) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end

  assign tx_data_o = r_tx_data;
  assign tx_wr_o   = r_tx_wr;
  assign busy_o    = r_busy;
  assign regs_o    = r_regs;
  assign debug_o   = r_regs[0];
endmodule
